in_fetch: RTL and testbench
===========================

# in_fetch

Read sequencer that drains a rectangular byte tile out of `mem_in` (32 KiB, 15-bit address, 1-cycle read latency, active-low CEN/WEN) and presents it as a valid/ready byte stream to the systolic-array input feeder. It sits directly downstream of `mem_in`, owns its read port during a transfer, and absorbs the SRAM latency with a small credit-managed FIFO so back-pressure never drops data.

## Interface
- `FIFO_DEPTH`, 4: output FIFO entries; must be ≥ 3 for full throughput, power of two.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only when `busy`=0.
- `base_addr`  in  15  address of tile element (0,0); sampled with `start`.
- `num_rows`  in  8  tile rows R; sampled with `start`.
- `num_cols`  in  8  tile columns C; sampled with `start`.
- `row_stride`  in  15  address distance between rows; sampled with `start`.
- `busy`  out  1  high from cycle after accepted `start` until `done` cycle inclusive.
- `done`  out  1  one-cycle pulse when last byte is accepted downstream.
- `mem_A`  out  15  read address to `mem_in`.
- `mem_CEN`  out  1  active-low chip enable; low only on an issued read.
- `mem_WEN`  out  1  constant 1 (never writes).
- `mem_Q`  in  8  read data from `mem_in`, valid the cycle after a read cycle.
- `out_data`  out  8  stream byte.
- `out_valid`  out  1  byte available.
- `out_ready`  in  1  consumer accepts when `out_valid` & `out_ready`.
- `out_eor`  out  1  qualifies `out_data` as last byte of a row (last of a column when transposed).

## Operation
- States: IDLE → FETCH → DRAIN → IDLE.
- IDLE: `start`=1 latches parameters, clears counters, enters FETCH. If R=0 or C=0: no reads, `done` pulses the next cycle, back to IDLE.
- FETCH: each cycle, issue one read (`mem_CEN`=0) iff FIFO occupancy + reads in flight < `FIFO_DEPTH`. Address = base + r·row_stride + c, computed incrementally; all arithmetic mod 2^15 (wraps 0x7FFF→0x0000). Order: c inner, r outer. After read (R-1, C-1) issued → DRAIN.
- DRAIN: no reads; wait until FIFO empty and no read in flight → `done`=1 for one cycle, IDLE.
- Read data captured into FIFO unconditionally the cycle after issue (credit scheme guarantees room). `out_eor` travels with the byte in the FIFO.
- `start` while `busy`=1 ignored. Parameter inputs ignored except at accepted `start`.
- Outputs registered: `mem_A`, `mem_CEN`; `mem_A` holds last value when idle.
- `out_valid`/`out_data` stable until accepted (no retraction).

## Timing
- Reset values: `busy`=0, `done`=0, `mem_CEN`=1, `mem_WEN`=1, `mem_A`=0, `out_valid`=0, `out_data`=0, `out_eor`=0; FIFO empty, state IDLE.
- `start` in cycle 0 → first read in cycle 1 → `mem_Q` valid cycle 2 → `out_valid` cycle 3.
- `out_ready` held 1: one byte per cycle, R·C reads in R·C consecutive cycles; `done` in cycle R·C+3.
- `out_ready`=0: reads stall once FIFO_DEPTH bytes are buffered/in flight; resume the cycle after a pop frees a credit.
- Simultaneous push and pop on full FIFO allowed; occupancy unchanged.
- `rst` mid-transfer: immediately returns to reset values; FIFO flushed; in-flight `mem_Q` discarded.

## Configuration
- `IN_FETCH_TRANSPOSE_EN` defined: traversal order r inner, c outer (column-major, address += row_stride per step, += 1 per column); `out_eor` marks last byte of each column. Undefined: row-major only, as above.

## Test plan
- base=0x0100, R=2, C=3, stride=0x10, ready=1 → reads 0x100,0x101,0x102,0x110,0x111,0x112 cycles 1–6; bytes out cycles 3–8; `out_eor` on 3rd and 6th; `done` cycle 9.
- Same tile, `out_ready` low cycles 3–10 → exactly 4 reads issued then `mem_CEN`=1; all 6 bytes delivered in order, none lost or duplicated.
- base=0x7FFE, R=1, C=4 → addresses 0x7FFE,0x7FFF,0x0000,0x0001.
- R=0, C=5, start → no `mem_CEN` low; `done` one cycle later; `busy` high for exactly that cycle.
- `rst` asserted mid-FETCH with 3 bytes buffered → all outputs at reset values same cycle; new `start` after release runs clean tile.
- With `IN_FETCH_TRANSPOSE_EN`, base=0, R=2, C=2, stride=8 → addresses 0,8,1,9; `out_eor` on 2nd and 4th byte.

Source files
------------

// File: rtl/in_fetch.sv
// in_fetch: read sequencer that walks a rectangular byte tile in mem_in and
// streams it out as valid/ready bytes. A credit counter (FIFO occupancy plus
// reads still in flight) bounds outstanding reads so the one-cycle SRAM
// latency never overruns the output FIFO under back-pressure.
// Build option: define IN_FETCH_TRANSPOSE_EN for column-major traversal.
module in_fetch #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [14:0] base_addr,
    input  logic [7:0]  num_rows,
    input  logic [7:0]  num_cols,
    input  logic [14:0] row_stride,
    output logic        busy,
    output logic        done,
    output logic [14:0] mem_A,
    output logic        mem_CEN,
    output logic        mem_WEN,
    input  logic [7:0]  mem_Q,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_eor
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t      state_reg, state_next;
    logic [14:0] cur_addr_reg, line_addr_reg;
    logic [7:0]  inner_cnt_reg, outer_cnt_reg, inner_max_reg, outer_max_reg;
    logic [14:0] inner_step_reg, outer_step_reg;
    logic [14:0] mem_a_reg;
    logic        mem_cen_reg, cen_eor_reg, pend_reg, pend_eor_reg;
    logic [8:0]  fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;

    // Traversal geometry: "inner" is the fast axis, "outer" the slow one.
    logic [7:0]  start_inner_n, start_outer_n;
    logic [14:0] start_inner_step, start_outer_step;
`ifdef IN_FETCH_TRANSPOSE_EN
    assign start_inner_n    = num_rows;
    assign start_outer_n    = num_cols;
    assign start_inner_step = row_stride;
    assign start_outer_step = 15'd1;
`else
    assign start_inner_n    = num_cols;
    assign start_outer_n    = num_rows;
    assign start_inner_step = 15'd1;
    assign start_outer_step = row_stride;
`endif

    logic [14:0] src_addr, src_line, src_inner_step, src_outer_step;
    logic [7:0]  src_inner, src_outer, src_inner_max, src_outer_max;
    logic [14:0] next_addr, next_line;
    logic [7:0]  next_inner, next_outer;
    logic        last_src, eor_src, issue, push, pop, credit_ok;
    logic [CW+1:0] credit_sum;

    assign push       = pend_reg;
    assign out_valid  = (count_reg != '0);
    assign pop        = out_valid & out_ready;
    assign credit_sum = {2'b00, count_reg} + {{(CW+1){1'b0}}, pend_reg}
                      + {{(CW+1){1'b0}}, ~mem_cen_reg} - {{(CW+1){1'b0}}, pop};
    assign credit_ok  = (credit_sum < (CW+2)'(FIFO_DEPTH));

    // Walker source (live inputs on the accepting start cycle) and the position after one issue.
    always_comb begin
        src_addr       = cur_addr_reg;
        src_line       = line_addr_reg;
        src_inner      = inner_cnt_reg;
        src_outer      = outer_cnt_reg;
        src_inner_max  = inner_max_reg;
        src_outer_max  = outer_max_reg;
        src_inner_step = inner_step_reg;
        src_outer_step = outer_step_reg;
        if (state_reg == IDLE) begin
            src_addr       = base_addr;
            src_line       = base_addr;
            src_inner      = 8'd0;
            src_outer      = 8'd0;
            src_inner_max  = start_inner_n - 8'd1;
            src_outer_max  = start_outer_n - 8'd1;
            src_inner_step = start_inner_step;
            src_outer_step = start_outer_step;
        end
        eor_src  = (src_inner == src_inner_max);
        last_src = eor_src && (src_outer == src_outer_max);
        if (eor_src) begin
            next_inner = 8'd0;
            next_outer = src_outer + 8'd1;
            next_line  = src_line + src_outer_step;
            next_addr  = src_line + src_outer_step;
        end else begin
            next_inner = src_inner + 8'd1;
            next_outer = src_outer;
            next_line  = src_line;
            next_addr  = src_addr + src_inner_step;
        end
    end

    // Next-state and read-issue decision.
    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (num_rows == 8'd0 || num_cols == 8'd0) begin
                        state_next = DRAIN;
                    end else begin
                        issue      = 1'b1;
                        state_next = last_src ? DRAIN : FETCH;
                    end
                end
            end
            FETCH: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (last_src) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (count_reg == '0 && !pend_reg && mem_cen_reg) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, latched geometry, walker position, registered SRAM port and read pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cur_addr_reg   <= '0;
            line_addr_reg  <= '0;
            inner_cnt_reg  <= '0;
            outer_cnt_reg  <= '0;
            inner_max_reg  <= '0;
            outer_max_reg  <= '0;
            inner_step_reg <= '0;
            outer_step_reg <= '0;
            mem_a_reg      <= '0;
            mem_cen_reg    <= 1'b1;
            cen_eor_reg    <= 1'b0;
            pend_reg       <= 1'b0;
            pend_eor_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start) begin
                inner_max_reg  <= src_inner_max;
                outer_max_reg  <= src_outer_max;
                inner_step_reg <= src_inner_step;
                outer_step_reg <= src_outer_step;
            end
            if (issue) begin
                mem_a_reg     <= src_addr;
                cur_addr_reg  <= next_addr;
                line_addr_reg <= next_line;
                inner_cnt_reg <= next_inner;
                outer_cnt_reg <= next_outer;
            end
            mem_cen_reg  <= ~issue;
            cen_eor_reg  <= issue & eor_src;
            pend_reg     <= ~mem_cen_reg;
            pend_eor_reg <= cen_eor_reg;
        end
    end

    // FIFO storage: capture returning read data, tagged with its end-of-line flag.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {pend_eor_reg, mem_Q};
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide on a full FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    assign busy     = (state_reg != IDLE);
    assign mem_A    = mem_a_reg;
    assign mem_CEN  = mem_cen_reg;
    assign mem_WEN  = 1'b1;
    assign out_data = out_valid ? fifo_mem[rd_ptr_reg][7:0] : 8'd0;
    assign out_eor  = out_valid ? fifo_mem[rd_ptr_reg][8] : 1'b0;

endmodule

// File: tb/tb_in_fetch.sv
// Bench for in_fetch: table of tiles with hand-listed read addresses and
// done cycles, a behavioural mem_in model, plus reset and busy-start sequences.
// Build with or without IN_FETCH_TRANSPOSE_EN; the expected tables follow it.
module tb_in_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [14:0] base_addr;
    logic [7:0]  num_rows, num_cols;
    logic [14:0] row_stride;
    logic        busy, done;
    logic [14:0] mem_A;
    logic        mem_CEN, mem_WEN;
    logic [7:0]  mem_Q = 8'd0;
    logic [7:0]  out_data;
    logic        out_valid, out_ready, out_eor;

    int checks = 0;
    int failures = 0;

    in_fetch #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .num_cols(num_cols), .row_stride(row_stride),
        .busy(busy), .done(done), .mem_A(mem_A), .mem_CEN(mem_CEN),
        .mem_WEN(mem_WEN), .mem_Q(mem_Q), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_eor(out_eor)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fdat(input logic [14:0] a);
        return a[7:0] ^ {1'b0, a[14:8]};
    endfunction

    // mem_in model: one-cycle registered read
    always @(posedge clk) begin
        if (!mem_CEN) mem_Q <= fdat(mem_A);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [14:0] base;
        logic [7:0]  rows;
        logic [7:0]  cols;
        logic [14:0] stride;
        bit          stall;
        bit          poke;
        int          n;
        int          done_cyc;
    } vec_t;

    localparam int NV = 8;
    vec_t        vecs [NV];
    logic [14:0] ea [NV][8];

    task automatic run_tile(input int id);
        vec_t v;
        int nrd, npop, done_at, inner_len, exp_rc;
        bit busy_bad;
        logic [14:0] ea_cur;
        v = vecs[id];
        nrd = 0; npop = 0; done_at = -1; busy_bad = 0;
`ifdef IN_FETCH_TRANSPOSE_EN
        inner_len = int'(v.rows);
`else
        inner_len = int'(v.cols);
`endif
        if (inner_len == 0) inner_len = 1;
        @(posedge clk); #1;
        start = 1'b1; base_addr = v.base; num_rows = v.rows;
        num_cols = v.cols; row_stride = v.stride; out_ready = 1'b1;
        for (int rel = 0; rel < 300 && done_at < 0; rel++) begin
            @(negedge clk);
            if (busy !== (rel >= 1)) busy_bad = 1;
            if (mem_CEN === 1'b0) begin
                if (nrd < 8) begin
                    ea_cur = ea[id][nrd];
                    chk($sformatf("v%0d rd%0d addr", id, nrd), 32'(mem_A), 32'(ea_cur));
                end
                exp_rc = (v.stall && nrd >= 4) ? nrd + 8 : nrd + 1;
                chk($sformatf("v%0d rd%0d cycle", id, nrd), rel, exp_rc);
                nrd++;
            end
            if (out_valid && out_ready) begin
                if (npop < 8) begin
                    ea_cur = ea[id][npop];
                    chk($sformatf("v%0d byte%0d data", id, npop), 32'(out_data), 32'(fdat(ea_cur)));
                    chk($sformatf("v%0d byte%0d eor", id, npop), 32'(out_eor),
                        32'(((npop + 1) % inner_len) == 0));
                end
                npop++;
            end
            if (done === 1'b1) done_at = rel;
            @(posedge clk); #1;
            start = (v.poke && rel + 1 == 2);
            if (start) begin
                base_addr = 15'h3333; num_rows = 8'd9; num_cols = 8'd9; row_stride = 15'h0777;
            end
            out_ready = !(v.stall && (rel + 1) >= 3 && (rel + 1) <= 10);
        end
        chk($sformatf("v%0d nreads", id), nrd, v.n);
        chk($sformatf("v%0d nbytes", id), npop, v.n);
        chk($sformatf("v%0d done_cycle", id), done_at, v.done_cyc);
        chk($sformatf("v%0d busy_window", id), 32'(busy_bad), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d busy_after", id), 32'(busy), 32'd0);
        chk($sformatf("v%0d done_pulse", id), 32'(done), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " mem_CEN"}, 32'(mem_CEN), 32'd1);
        chk({tag, " mem_WEN"}, 32'(mem_WEN), 32'd1);
        chk({tag, " mem_A"}, 32'(mem_A), 32'd0);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " out_data"}, 32'(out_data), 32'd0);
        chk({tag, " out_eor"}, 32'(out_eor), 32'd0);
    endtask

    initial begin
        // base, rows, cols, stride, stall, poke, n, done_cyc
        vecs[0] = '{15'h0100, 8'd2, 8'd3, 15'h0010, 1'b0, 1'b1, 6, 9};
        vecs[1] = '{15'h0100, 8'd2, 8'd3, 15'h0010, 1'b1, 1'b0, 6, 17};
        vecs[2] = '{15'h7FFE, 8'd1, 8'd4, 15'h0020, 1'b0, 1'b0, 4, 7};
        vecs[3] = '{15'h0040, 8'd0, 8'd5, 15'h0010, 1'b0, 1'b0, 0, 1};
        vecs[4] = '{15'h0010, 8'd3, 8'd2, 15'h7FF8, 1'b0, 1'b0, 6, 9};
        vecs[5] = '{15'h0055, 8'd1, 8'd1, 15'h0001, 1'b0, 1'b0, 1, 4};
        vecs[6] = '{15'h0000, 8'd2, 8'd2, 15'h0008, 1'b0, 1'b0, 4, 7};
        vecs[7] = '{15'h0200, 8'd5, 8'd0, 15'h0010, 1'b0, 1'b0, 0, 1};
`ifdef IN_FETCH_TRANSPOSE_EN
        ea[0] = '{15'h100, 15'h110, 15'h101, 15'h111, 15'h102, 15'h112, 15'h0, 15'h0};
        ea[1] = '{15'h100, 15'h110, 15'h101, 15'h111, 15'h102, 15'h112, 15'h0, 15'h0};
        ea[4] = '{15'h010, 15'h008, 15'h000, 15'h011, 15'h009, 15'h001, 15'h0, 15'h0};
        ea[6] = '{15'h000, 15'h008, 15'h001, 15'h009, 15'h0, 15'h0, 15'h0, 15'h0};
`else
        ea[0] = '{15'h100, 15'h101, 15'h102, 15'h110, 15'h111, 15'h112, 15'h0, 15'h0};
        ea[1] = '{15'h100, 15'h101, 15'h102, 15'h110, 15'h111, 15'h112, 15'h0, 15'h0};
        ea[4] = '{15'h010, 15'h011, 15'h008, 15'h009, 15'h000, 15'h001, 15'h0, 15'h0};
        ea[6] = '{15'h000, 15'h001, 15'h008, 15'h009, 15'h0, 15'h0, 15'h0, 15'h0};
`endif
        ea[2] = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001, 15'h0, 15'h0, 15'h0, 15'h0};
        ea[3] = '{15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0};
        ea[5] = '{15'h0055, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0};
        ea[7] = '{15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0};

        rst = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0; num_cols = '0;
        row_stride = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        for (int i = 0; i < NV; i++) run_tile(i);

        // Reset in the middle of a fetch with three bytes buffered
        @(posedge clk); #1;
        start = 1'b1; base_addr = 15'h0100; num_rows = 8'd2; num_cols = 8'd3;
        row_stride = 15'h0010; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("midrst busy_before", 32'(busy), 32'd1);
        chk("midrst valid_before", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        run_tile(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
